// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard and the register file.
package reg_scoreboard_pkg;

    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned STALL_CNT_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam reg_addr_t R0_IDX  = REG_ADDR_W'(0);
    localparam cnt_t      CNT_MAX = {CNT_W{1'b1}};

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one register's pending-write count, saturating in both directions.
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output cnt_t cnt
);

    // Up/down count; simultaneous inc and dec leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-stage RAW/WAW hazard controller for the 8x16 register file.
// Optional build macro SCOREBOARD_BYPASS_EN: a same-cycle writeback releases
// the hazard it resolves (data is forwarded from writeback).
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_ra,
    input  logic [REG_ADDR_W-1:0]  issue_rb,
    input  logic [REG_ADDR_W-1:0]  issue_rw,
    input  logic                   issue_use_a,
    input  logic                   issue_use_b,
    input  logic                   issue_wr,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [REG_ADDR_W-1:0]  wb_rw,
    input  logic                   flush,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   err_underflow
);

    cnt_t cnt [NUM_REGS];
    logic raw_a, raw_b, waw_full, stall, issue_fire;
    logic inc_any, dec_any, underflow;

    // R0 is hard-wired zero and never tracked.
    assign cnt[0] = '0;

    // One counter per real register; flush clears, and blocks dec that cycle.
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
        logic inc_i, dec_i;
        assign inc_i = inc_any && (issue_rw == REG_ADDR_W'(i));
        assign dec_i = dec_any && (wb_rw == REG_ADDR_W'(i));
        sb_counter u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc_i),
            .dec   (dec_i),
            .clr   (flush),
            .cnt   (cnt[i])
        );
    end

    // Hazard detection; issue_ready is combinational on issue/wb/flush.
    always_comb begin
        raw_a    = 1'b0;
        raw_b    = 1'b0;
        waw_full = 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
        raw_a    = issue_use_a && (cnt[issue_ra] != '0)
                   && !((cnt[issue_ra] == CNT_W'(1)) && wb_valid && (wb_rw == issue_ra));
        raw_b    = issue_use_b && (cnt[issue_rb] != '0)
                   && !((cnt[issue_rb] == CNT_W'(1)) && wb_valid && (wb_rw == issue_rb));
        waw_full = issue_wr && (issue_rw != R0_IDX) && (cnt[issue_rw] == CNT_MAX)
                   && !(wb_valid && (wb_rw == issue_rw));
`else
        raw_a    = issue_use_a && (cnt[issue_ra] != '0);
        raw_b    = issue_use_b && (cnt[issue_rb] != '0);
        waw_full = issue_wr && (issue_rw != R0_IDX) && (cnt[issue_rw] == CNT_MAX);
`endif
        stall       = issue_valid && (raw_a || raw_b || waw_full || flush);
        issue_ready = !stall;
        issue_fire  = issue_valid && issue_ready;
        inc_any     = issue_fire && issue_wr && (issue_rw != R0_IDX);
        dec_any     = wb_valid && !flush && (wb_rw != R0_IDX) && (cnt[wb_rw] != '0);
        underflow   = wb_valid && !flush && (wb_rw != R0_IDX) && (cnt[wb_rw] == '0);
    end

    // Busy bits mirror the registered counts.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_mask[i] = (cnt[i] != '0);
        end
    end

    // Saturating stall counter and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles  <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (stall && (stall_cycles != {STALL_CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios followed by random traffic.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_ra = '0, issue_rb = '0, issue_rw = '0;
    logic        issue_use_a = 1'b0, issue_use_b = 1'b0, issue_wr = 1'b0;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_rw = '0;
    logic        flush = 1'b0;
    logic [7:0]  busy_mask;
    logic [15:0] stall_cycles;
    logic        err_underflow;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ra      (issue_ra),
        .issue_rb      (issue_rb),
        .issue_rw      (issue_rw),
        .issue_use_a   (issue_use_a),
        .issue_use_b   (issue_use_b),
        .issue_wr      (issue_wr),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_rw         (wb_rw),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .stall_cycles  (stall_cycles),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        ready;
        bit [7:0]  busy;
        int        stalls;
        bit        err;
        int        cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;
    int   cycle = 0;

    // Reference state: pending writes per register, stall tally, sticky error.
    int m_cnt[8];
    int m_stall = 0;
    bit m_err   = 0;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic bit src_blocked(int r, bit wbv, int wbr);
        if (m_cnt[r] == 0) return 0;
        if (BYP && m_cnt[r] == 1 && wbv && wbr == r) return 0;
        return 1;
    endfunction

    // Drive one cycle, queue the expected outputs, then advance the model.
    task automatic cyc(bit v, int ra, int rb, int rw, bit ua, bit ub, bit wr,
                       bit wbv, int wbr, bit fl, bit rst);
        exp_t e;
        bit   blocked, fire;
        @(posedge clk); #1;
        issue_valid = v;   issue_ra = 3'(ra); issue_rb = 3'(rb); issue_rw = 3'(rw);
        issue_use_a = ua;  issue_use_b = ub;  issue_wr = wr;
        wb_valid = wbv;    wb_rw = 3'(wbr);   flush = fl;  reset = rst;
        blocked = fl || (ua && src_blocked(ra, wbv, wbr)) || (ub && src_blocked(rb, wbv, wbr))
                  || (wr && rw != 0 && m_cnt[rw] == 3 && !(BYP && wbv && wbr == rw));
        e.ready  = !(v && blocked);
        e.busy   = '0;
        for (int i = 1; i < 8; i++) e.busy[i] = (m_cnt[i] != 0);
        e.stalls = m_stall;
        e.err    = m_err;
        e.cyc    = cycle;
        exp_q.push_back(e);
        cycle++;
        fire = v && !blocked;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_stall = 0;
            m_err   = 0;
        end else begin
            if (v && blocked && m_stall < 65535) m_stall++;
            if (fl) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                if (wbv && wbr != 0) begin
                    if (m_cnt[wbr] == 0) m_err = 1;
                    else m_cnt[wbr]--;
                end
                if (fire && wr && rw != 0) m_cnt[rw]++;
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (issue_ready !== e.ready) begin
                    bad++;
                    $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, issue_ready, e.ready);
                end
                total++;
                if (busy_mask !== e.busy) begin
                    bad++;
                    $display("FAIL busy_mask cyc=%0d got=%b exp=%b", e.cyc, busy_mask, e.busy);
                end
                total++;
                if (stall_cycles !== 16'(e.stalls)) begin
                    bad++;
                    $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cycles, e.stalls);
                end
                total++;
                if (err_underflow !== e.err) begin
                    bad++;
                    $display("FAIL err_underflow cyc=%0d got=%b exp=%b", e.cyc, err_underflow, e.err);
                end
            end
        end
    end

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // 1: RAW on R3, stall several cycles, then retire R3.
        cyc(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 3, 0, 1, 1, 0, 0, 1, 3, 0, 0);
        cyc(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(1);
        // 2: WAW saturation on R5.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 5, 0, 0, 1, 1, 5, 0, 0);
        cyc(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // 3: simultaneous inc/dec on R2.
        cyc(1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 2, 0, 0, 1, 1, 2, 0, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        // 4: R0 ignored, then underflow on R6 sticks.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // 5: flush with R1 and R4 pending, issue and wb in the same cycle.
        cyc(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 2, 0, 0, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // 6: reset mid-operation with R7 pending and 5 stalled cycles.
        cyc(1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 7, 7, 0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        idle(1);
        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 4) != 0, $urandom % 8, $urandom % 8, $urandom % 8,
                $urandom % 2, $urandom % 2, $urandom % 2,
                ($urandom % 5) < 2, $urandom % 8,
                ($urandom % 40) == 0, ($urandom % 100) == 0);
        end
        idle(2);
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
